rv32_mem_arbiter: RTL

Arbitrates the instruction-fetch (IF) and data-memory (MEM stage) requesters of rv32_pipelined onto one shared single-port, fixed-latency memory. It carries one transaction at a time and generates the per-stage stall signals the pipeline holds on. Data accesses have priority, with a starvation guard that protects instruction fetch. It sits between the pipeline core and the unified instruction/data memory.

---
 rtl/rv32_mem_pkg.sv | 21 ++
 rtl/rv32_mem_lat_timer.sv | 40 ++++
 rtl/rv32_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// rv32_mem_pkg : shared types and constants for the IF/DM memory arbiter
// Revision     : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic       REQ_IF  = 1'b0;
  localparam logic       REQ_DM  = 1'b1;
  localparam logic [3:0] BE_FULL = 4'hF;
  localparam int         LAT_CW  = 4;

endpackage
`default_nettype wire

// File: rtl/rv32_mem_lat_timer.sv
`default_nettype none
// ============================================================================
// rv32_mem_lat_timer : loadable down-counter with zero flag (max latency 15)
// Revision           : 1.0 - initial release
// ============================================================================
module rv32_mem_lat_timer
  import rv32_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LAT_CW-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [LAT_CW-1:0] cnt_q;
  logic [LAT_CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// rv32_mem_arbiter : IF/DM arbiter onto one fixed-latency single-port memory
// Revision         : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  if ((MEM_LAT < 1) || (MEM_LAT > 15) || (DATA_W != 32)) begin : g_param_err
    $error("rv32_mem_arbiter: MEM_LAT must be 1..15 and DATA_W must be 32");
  end

  state_t             state_q, state_d;
  logic               winner_q, winner_d;
  logic               store_q, store_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic               dm_rvalid_q, dm_rvalid_d;

  logic               starve_max;
  logic               win_sel;
  logic               grant;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;

  assign starve_max = (starve_q == STV_W'(STARVE_MAX));

  // Data side wins ties unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    win_sel = REQ_IF;
    if (dm_req && (!if_req || !starve_max)) begin
      win_sel = REQ_DM;
    end
  end

  assign grant  = ~rst & (state_q == ST_IDLE) & (if_req | dm_req);
  assign if_gnt = grant & (win_sel == REQ_IF);
  assign dm_gnt = grant & (win_sel == REQ_DM);

  rv32_mem_lat_timer u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LAT_CW'(MEM_LAT - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    store_d     = store_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d  = ST_CMD;
          winner_d = win_sel;
          tmr_load = 1'b1;
          mem_en_d = 1'b1;
          if (win_sel == REQ_DM) begin
            store_d     = dm_we;
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            store_d    = 1'b0;
            mem_be_d   = BE_FULL;
            mem_addr_d = if_addr;
          end
        end
      end
      // Timer holds MEM_LAT-1 during CMD, so a zero here means the data is due next cycle.
      ST_CMD, ST_WAIT: begin
        if (tmr_zero) begin
          state_d     = ST_RESP;
          if_rvalid_d = (winner_q == REQ_IF);
          dm_rvalid_d = (winner_q == REQ_DM);
        end else begin
          state_d = ST_WAIT;
          tmr_dec = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt && !starve_max) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= REQ_IF;
      store_q     <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      store_q     <= store_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rvalid_q ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid_q && !store_q) ? mem_rdata : '0;
  assign stall_if  = if_req & ~if_rvalid_q;
  assign stall_mem = dm_req & ~dm_rvalid_q;

endmodule
`default_nettype wire
